// File: rtl/seq_pkg.sv
// Shared definitions for the sequence engine: run modes and FSM state encoding.
package seq_pkg;

    localparam logic [1:0] MODE_FIB    = 2'd0;
    localparam logic [1:0] MODE_ARITH  = 2'd1;
    localparam logic [1:0] MODE_DOUBLE = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEED = 3'd1,
        ST_CALC = 3'd2,
        ST_EMIT = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/seq_regfile.sv
// Term storage: one write port, one registered read port, synchronous clear.
// A read of an entry written on the same edge returns the old contents.
module seq_regfile #(
    parameter int WIDTH = 16,
    parameter int NREGS = 16,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [NREGS];
    logic [WIDTH-1:0] rdata_q;

    // Storage write and gated read; re_i low forces the read data to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NREGS; k++) begin
                mem_q[k] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (we_i) begin
                mem_q[waddr_i] <= wdata_i;
            end
            rdata_q <= re_i ? mem_q[raddr_i] : '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/seq_engine.sv
// Sequence generator: FIB / ARITH / DOUBLE terms into a register file,
// streamed out over a valid/ready handshake.
// Handshake: out_valid rises with a new term and stays high with out_data
// stable until the edge where out_valid && out_ready; the term is consumed
// on that edge and out_valid drops there.
module seq_engine
    import seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 16,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] seed_a,
    input  logic [WIDTH-1:0] seed_b,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [AW:0]      count,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             zero_fl,
    output logic             neg_fl,
    output logic [2:0]       state_dbg
);

    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(NREGS);

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] seed_a_q, seed_a_d;
    logic [WIDTH-1:0] seed_b_q, seed_b_d;
    logic [WIDTH-1:0] prev1_q, prev1_d;   // r[i-1]
    logic [WIDTH-1:0] prev2_q, prev2_d;   // r[i-2]
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             overflow_q, overflow_d;
    logic [CW-1:0]    count_q, count_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;

    logic             is_fib;
    logic [WIDTH-1:0] operand;
    logic [WIDTH:0]   sum;
    logic             wr_term;
    logic [WIDTH-1:0] term;
    logic             rd_en;

    // Reserved mode 3 falls back to Fibonacci behaviour.
    assign is_fib = (mode_q != MODE_ARITH) && (mode_q != MODE_DOUBLE);

    // Second adder operand selected by mode; the carry-out is the overflow.
    always_comb begin
        operand = prev2_q;
        if (mode_q == MODE_ARITH) begin
            operand = seed_b_q;
        end else if (mode_q == MODE_DOUBLE) begin
            operand = prev1_q;
        end
    end

    assign sum = {1'b0, prev1_q} + {1'b0, operand};

    // Next-state and datapath control; a term write is shared by SEED and CALC.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        seed_a_d    = seed_a_q;
        seed_b_d    = seed_b_q;
        prev1_d     = prev1_q;
        prev2_d     = prev2_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = done_q;
        overflow_d  = overflow_q;
        count_d     = count_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        wr_term     = 1'b0;
        term        = '0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    mode_d     = mode;
                    seed_a_d   = seed_a;
                    seed_b_d   = seed_b;
                    count_d    = '0;
                    overflow_d = 1'b0;
                    done_d     = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = ST_SEED;
                end
            end
            ST_SEED: begin
                wr_term = 1'b1;
                term    = (count_q == '0) ? seed_a_q : seed_b_q;
            end
            ST_CALC: begin
                if (sum[WIDTH]) begin
                    overflow_d = 1'b1;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    wr_term = 1'b1;
                    term    = sum[WIDTH-1:0];
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (count_q == FULL_C) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else if (is_fib && (count_q == CW'(1))) begin
                        state_d = ST_SEED;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (wr_term) begin
            out_data_d  = term;
            out_valid_d = 1'b1;
            count_d     = count_q + CW'(1);
            prev2_d     = prev1_q;
            prev1_d     = term;
            zero_d      = (term == '0);
            neg_d       = term[WIDTH-1];
            state_d     = ST_EMIT;
        end
    end

    // State and output registers; reset discards any pending term.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mode_q      <= '0;
            seed_a_q    <= '0;
            seed_b_q    <= '0;
            prev1_q     <= '0;
            prev2_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            count_q     <= '0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            seed_a_q    <= seed_a_d;
            seed_b_q    <= seed_b_d;
            prev1_q     <= prev1_d;
            prev2_q     <= prev2_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
            count_q     <= count_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
        end
    end

    // Entries at or beyond the current count read back as zero.
    assign rd_en = ({1'b0, rd_addr} < count_q);

    seq_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we_i    (wr_term),
        .waddr_i (count_q[AW-1:0]),
        .wdata_i (term),
        .re_i    (rd_en),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = overflow_q;
    assign count     = count_q;
    assign zero_fl   = zero_q;
    assign neg_fl    = neg_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_seq_engine.sv
// Bench for seq_engine: five instances cover the parameter sets needed
// (A: W16/N16, B: W16/N32, C: W16/N8, D: W8/N16, E: W16/N2); one is
// selected at a time and its outputs are muxed onto common monitor signals.
module tb_seq_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  st = '0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] seed_a = '0;
    logic [15:0] seed_b = '0;
    logic        out_ready = 1'b1;
    logic [4:0]  rd_addr = '0;
    int          sel = 0;

    always #5 clk = ~clk;

    logic [15:0] a_data, b_data, c_data, e_data, a_rd, b_rd, c_rd, e_rd;
    logic [7:0]  d_data, d_rd;
    logic [4:0]  a_cnt, d_cnt;
    logic [5:0]  b_cnt;
    logic [3:0]  c_cnt;
    logic [1:0]  e_cnt;
    logic [4:0]  v_valid, v_busy, v_done, v_ovf, v_zero, v_neg;
    logic [2:0]  a_st, b_st, c_st, d_st, e_st;

    seq_engine #(.WIDTH(16), .NREGS(16)) u_a (
        .clk(clk), .reset(reset), .start(st[0]), .mode(mode), .seed_a(seed_a), .seed_b(seed_b),
        .out_data(a_data), .out_valid(v_valid[0]), .out_ready(out_ready), .busy(v_busy[0]),
        .done(v_done[0]), .overflow(v_ovf[0]), .count(a_cnt), .rd_addr(rd_addr[3:0]),
        .rd_data(a_rd), .zero_fl(v_zero[0]), .neg_fl(v_neg[0]), .state_dbg(a_st));
    seq_engine #(.WIDTH(16), .NREGS(32)) u_b (
        .clk(clk), .reset(reset), .start(st[1]), .mode(mode), .seed_a(seed_a), .seed_b(seed_b),
        .out_data(b_data), .out_valid(v_valid[1]), .out_ready(out_ready), .busy(v_busy[1]),
        .done(v_done[1]), .overflow(v_ovf[1]), .count(b_cnt), .rd_addr(rd_addr[4:0]),
        .rd_data(b_rd), .zero_fl(v_zero[1]), .neg_fl(v_neg[1]), .state_dbg(b_st));
    seq_engine #(.WIDTH(16), .NREGS(8)) u_c (
        .clk(clk), .reset(reset), .start(st[2]), .mode(mode), .seed_a(seed_a), .seed_b(seed_b),
        .out_data(c_data), .out_valid(v_valid[2]), .out_ready(out_ready), .busy(v_busy[2]),
        .done(v_done[2]), .overflow(v_ovf[2]), .count(c_cnt), .rd_addr(rd_addr[2:0]),
        .rd_data(c_rd), .zero_fl(v_zero[2]), .neg_fl(v_neg[2]), .state_dbg(c_st));
    seq_engine #(.WIDTH(8), .NREGS(16)) u_d (
        .clk(clk), .reset(reset), .start(st[3]), .mode(mode), .seed_a(seed_a[7:0]), .seed_b(seed_b[7:0]),
        .out_data(d_data), .out_valid(v_valid[3]), .out_ready(out_ready), .busy(v_busy[3]),
        .done(v_done[3]), .overflow(v_ovf[3]), .count(d_cnt), .rd_addr(rd_addr[3:0]),
        .rd_data(d_rd), .zero_fl(v_zero[3]), .neg_fl(v_neg[3]), .state_dbg(d_st));
    seq_engine #(.WIDTH(16), .NREGS(2)) u_e (
        .clk(clk), .reset(reset), .start(st[4]), .mode(mode), .seed_a(seed_a), .seed_b(seed_b),
        .out_data(e_data), .out_valid(v_valid[4]), .out_ready(out_ready), .busy(v_busy[4]),
        .done(v_done[4]), .overflow(v_ovf[4]), .count(e_cnt), .rd_addr(rd_addr[0:0]),
        .rd_data(e_rd), .zero_fl(v_zero[4]), .neg_fl(v_neg[4]), .state_dbg(e_st));

    // Selected-instance view.
    logic [15:0] m_data, m_rd;
    logic [5:0]  m_cnt;
    logic [2:0]  m_st;
    logic        m_valid, m_busy, m_done, m_ovf, m_zero, m_neg;

    always_comb begin
        m_valid = v_valid[sel];
        m_busy  = v_busy[sel];
        m_done  = v_done[sel];
        m_ovf   = v_ovf[sel];
        m_zero  = v_zero[sel];
        m_neg   = v_neg[sel];
        case (sel)
            1:       begin m_data = b_data; m_rd = b_rd; m_cnt = b_cnt; m_st = b_st; end
            2:       begin m_data = c_data; m_rd = c_rd; m_cnt = {2'b0, c_cnt}; m_st = c_st; end
            3:       begin m_data = {8'h0, d_data}; m_rd = {8'h0, d_rd}; m_cnt = {1'b0, d_cnt}; m_st = d_st; end
            4:       begin m_data = e_data; m_rd = e_rd; m_cnt = {4'b0, e_cnt}; m_st = e_st; end
            default: begin m_data = a_data; m_rd = a_rd; m_cnt = {1'b0, a_cnt}; m_st = a_st; end
        endcase
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Scoreboard: expected terms from a small reference model.
    logic [15:0] exp_q[$];
    logic [15:0] last_term = '0;
    logic        mon_en = 1'b0;
    logic        gap_en = 1'b0;
    logic        have_prev = 1'b0;
    int          last_acc = 0;

    function automatic void build_exp(input logic [1:0] md, input int a, input int b,
                                      input int width, input int nregs);
        int lim, p1, p2, t, n;
        bit fib;
        lim = 1 << width;
        fib = (md != 2'd1) && (md != 2'd2);
        exp_q.delete();
        exp_q.push_back(16'(a));
        p1 = a; p2 = 0; n = 1;
        if (fib && n < nregs) begin
            exp_q.push_back(16'(b));
            p2 = p1; p1 = b; n = 2;
        end
        while (n < nregs) begin
            if (fib)           t = p1 + p2;
            else if (md == 1)  t = p1 + b;
            else               t = p1 + p1;
            if (t >= lim) break;
            exp_q.push_back(16'(t));
            p2 = p1; p1 = t; n++;
        end
    endfunction

    // Each accepted term is checked against the head of the expected queue.
    always @(negedge clk) begin
        if (mon_en && m_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_term", 32'(m_data), 32'hFFFF_FFFF);
            end else begin
                check("term", 32'(m_data), 32'(exp_q.pop_front()));
            end
            if (gap_en && have_prev) check("term_gap", 32'(cyc - last_acc), 32'd2);
            have_prev = 1'b1;
            last_acc  = cyc;
            last_term = m_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic start_pulse();
        st[sel] = 1'b1;
        tick();
        st = '0;
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget; k++) begin
            if (m_done) break;
            tick();
        end
        check("done_reached", 32'(m_done), 32'd1);
    endtask

    typedef struct {
        int          inst;
        logic [1:0]  md;
        logic [15:0] a;
        logic [15:0] b;
        int          width;
        int          nregs;
        int          exp_count;
        logic        exp_ovf;
        logic [15:0] exp_last;
        logic        exp_neg;
        logic [4:0]  raddr;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v);
        sel = v.inst;
        mode = v.md; seed_a = v.a; seed_b = v.b;
        build_exp(v.md, int'(v.a), int'(v.b), v.width, v.nregs);
        have_prev = 1'b0;
        mon_en = 1'b1;
        start_pulse();
        wait_done(500);
        tick();
        mon_en = 1'b0;
        check("count", 32'(m_cnt), 32'(v.exp_count));
        check("overflow", 32'(m_ovf), 32'(v.exp_ovf));
        check("last_term", 32'(last_term), 32'(v.exp_last));
        check("neg_fl", 32'(m_neg), 32'(v.exp_neg));
        check("zero_fl", 32'(m_zero), 32'd0);
        check("busy_end", 32'(m_busy), 32'd0);
        check("valid_end", 32'(m_valid), 32'd0);
        check("drained", 32'(exp_q.size()), 32'd0);
        rd_addr = v.raddr;
        tick();
        tick();
        check("rd_data", 32'(m_rd), 32'(v.exp_rd));
    endtask

    initial begin
        //          inst mode  a        b      W   N   cnt ovf last     neg raddr rd
        vecs[0] = '{0, 2'd0, 16'd0,    16'd1, 16, 16, 16, 0, 16'd610,   0, 15, 16'd610};
        vecs[1] = '{1, 2'd0, 16'd1,    16'd1, 16, 32, 24, 1, 16'd46368, 1, 24, 16'd0};
        vecs[2] = '{2, 2'd1, 16'hFFF0, 16'd4, 16, 8,  4,  1, 16'hFFFC,  1, 3,  16'hFFFC};
        vecs[3] = '{3, 2'd2, 16'd1,    16'd0, 8,  16, 8,  1, 16'd128,   1, 7,  16'd128};
        vecs[4] = '{4, 2'd0, 16'd5,    16'd7, 16, 2,  2,  0, 16'd7,     0, 1,  16'd7};
        vecs[5] = '{0, 2'd3, 16'd2,    16'd3, 16, 16, 16, 0, 16'd2584,  0, 0,  16'd2};

        do_reset();
        sel = 0;
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_busy", 32'(m_busy), 32'd0);
        check("rst_done", 32'(m_done), 32'd0);
        check("rst_ovf", 32'(m_ovf), 32'd0);
        check("rst_count", 32'(m_cnt), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_rd", 32'(m_rd), 32'd0);
        check("rst_state", 32'(m_st), 32'd0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // First-term latency and two-cycle cadence (ARITH 5 step 3 on A).
        sel = 0; mode = 2'd1; seed_a = 16'd5; seed_b = 16'd3;
        build_exp(2'd1, 5, 3, 16, 16);
        have_prev = 1'b0; gap_en = 1'b1; mon_en = 1'b1;
        start_pulse();
        check("lat_valid_seed", 32'(m_valid), 32'd0);
        check("lat_state_seed", 32'(m_st), 32'd1);
        check("lat_busy", 32'(m_busy), 32'd1);
        tick();
        check("lat_valid", 32'(m_valid), 32'd1);
        check("lat_data", 32'(m_data), 32'd5);
        wait_done(500);
        tick();
        mon_en = 1'b0; gap_en = 1'b0;
        check("lat_count", 32'(m_cnt), 32'd16);
        check("lat_drained", 32'(exp_q.size()), 32'd0);

        // Backpressure on the third FIB term.
        sel = 0; mode = 2'd0; seed_a = 16'd0; seed_b = 16'd1;
        build_exp(2'd0, 0, 1, 16, 16);
        have_prev = 1'b0; mon_en = 1'b1;
        start_pulse();
        for (int k = 0; k < 50; k++) begin
            if (m_st == 3'd2) break;
            tick();
        end
        check("bp_reach_calc", 32'(m_st), 32'd2);
        out_ready = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", 32'(m_valid), 32'd1);
            check("bp_data", 32'(m_data), 32'd1);
            check("bp_count", 32'(m_cnt), 32'd3);
            check("bp_state", 32'(m_st), 32'd3);
            tick();
        end
        out_ready = 1'b1;
        wait_done(500);
        tick();
        mon_en = 1'b0;
        check("bp_final_count", 32'(m_cnt), 32'd16);
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // Second start mid-run on DOUBLE/W8 is ignored.
        sel = 3; mode = 2'd2; seed_a = 16'd1; seed_b = 16'd0;
        build_exp(2'd2, 1, 0, 8, 16);
        have_prev = 1'b0; mon_en = 1'b1;
        start_pulse();
        repeat (5) tick();
        mode = 2'd0; seed_a = 16'd3; seed_b = 16'd3;
        start_pulse();
        wait_done(500);
        tick();
        mon_en = 1'b0;
        check("rs_count", 32'(m_cnt), 32'd8);
        check("rs_ovf", 32'(m_ovf), 32'd1);
        check("rs_last", 32'(last_term), 32'd128);
        check("rs_drained", 32'(exp_q.size()), 32'd0);

        // Reset after three terms, then a clean rerun.
        sel = 0; mode = 2'd0; seed_a = 16'd0; seed_b = 16'd1;
        start_pulse();
        for (int k = 0; k < 50; k++) begin
            if (m_cnt == 6'd3) break;
            tick();
        end
        check("mr_reach3", 32'(m_cnt), 32'd3);
        reset = 1'b1;
        tick();
        check("mr_valid", 32'(m_valid), 32'd0);
        check("mr_busy", 32'(m_busy), 32'd0);
        check("mr_done", 32'(m_done), 32'd0);
        check("mr_count", 32'(m_cnt), 32'd0);
        check("mr_state", 32'(m_st), 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 16; k++) begin
            rd_addr = 5'(k);
            tick();
            tick();
            check("mr_rd_zero", 32'(m_rd), 32'd0);
        end
        run_vec(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
